// File: rtl/strike_pkg.sv
// Shared types and constants for the drum-strike SPI event transmitter.
// Frame layout: [15] valid, [14] overflow-at-capture, [13:12] sequence, [11:0] magnitude.
package strike_pkg;

   localparam int FRAME_BITS = 16;
   localparam int MAG_SHIFT  = 4;
   localparam int SEQ_BITS   = 2;
   localparam int MAG_BITS   = FRAME_BITS - 2 - SEQ_BITS;

   typedef struct packed {
      logic                valid;
      logic                ovf;
      logic [SEQ_BITS-1:0] seq;
      logic [MAG_BITS-1:0] mag;
   } strike_frame_t;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;

   // 17-bit absolute value so that -32768 becomes 32768 and scales to 2048 without saturation.
   function automatic logic [MAG_BITS-1:0] gyro_mag(input logic signed [15:0] g);
      logic [16:0] abs_v;
      abs_v = g[15] ? (17'd0 - {g[15], g}) : {1'b0, g};
      return MAG_BITS'(abs_v >> MAG_SHIFT);
   endfunction

endpackage

// File: rtl/strike_event_fifo.sv
// Small synchronous FIFO with first-word-fall-through head, count, and pop-before-push
// priority so a push into a full FIFO succeeds when a pop happens in the same cycle.
module strike_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign w_pop_ok  = pop & (r_count != '0);
   assign w_push_ok = push & ((r_count != DEPTH_CNT) | w_pop_ok);

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == DEPTH_CNT);
   assign empty = (r_count == '0);
   assign count = r_count;

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/strike_event_tx.sv
// Strike events -> FIFO -> SPI slave (mode 0) drained by the MCU, one frame per cs_n transaction.
// STRIKE_TX_SYNC_EN adds 2-flop synchronizers on sclk/cs_n; otherwise they are taken as clk-synchronous.
module strike_event_tx
   import strike_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               strike_in,
   input  logic signed [15:0] gyro_y,
   input  logic               sclk,
   input  logic               cs_n,
   output logic               miso,
   output logic               irq,
   output logic               overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(FRAME_BITS);

   logic w_sclk_s, w_cs_s;

`ifdef STRIKE_TX_SYNC_EN
   logic [1:0] r_sclk_sync, r_cs_sync;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= 2'b00;
         r_cs_sync   <= 2'b11;
      end else begin
         r_sclk_sync <= {r_sclk_sync[0], sclk};
         r_cs_sync   <= {r_cs_sync[0], cs_n};
      end
   end
   assign w_sclk_s = r_sclk_sync[1];
   assign w_cs_s   = r_cs_sync[1];
`else
   assign w_sclk_s = sclk;
   assign w_cs_s   = cs_n;
`endif

   logic r_sclk_d, r_cs_d;
   logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_cs_fall   = ~w_cs_s & r_cs_d;
   assign w_cs_rise   = w_cs_s & ~r_cs_d;

   tx_state_t             r_state, w_state_next;
   logic [FRAME_BITS-1:0] r_shift, w_shift_next;
   logic [BW-1:0]         r_bit_cnt, w_bit_cnt_next;
   logic                  r_loaded_valid, w_loaded_valid_next;
   logic [SEQ_BITS-1:0]   r_seq;
   logic                  r_overflow;
   logic                  r_irq;
   logic                  w_pop, w_push;
   logic [FRAME_BITS-1:0] w_head;
   logic                  w_fifo_full, w_fifo_empty;
   logic [CW-1:0]         w_count;
   strike_frame_t         w_new_frame;

   assign w_new_frame = '{valid: 1'b1, ovf: r_overflow, seq: r_seq, mag: gyro_mag(gyro_y)};
   assign w_push      = strike_in & (~w_fifo_full | w_pop);

   strike_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FRAME_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .din   (w_new_frame),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_count)
   );

   always_comb begin
      w_state_next        = r_state;
      w_shift_next        = r_shift;
      w_bit_cnt_next      = r_bit_cnt;
      w_loaded_valid_next = r_loaded_valid;
      w_pop               = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_cs_fall) begin
               w_shift_next        = w_fifo_empty ? '0 : w_head;
               w_loaded_valid_next = ~w_fifo_empty & w_head[FRAME_BITS-1];
               w_bit_cnt_next      = '0;
               w_state_next        = SHIFT;
            end
         end
         SHIFT: begin
            if (w_cs_rise) begin
               w_state_next = IDLE;
            end else begin
               if (w_sclk_rise) begin
                  w_bit_cnt_next = r_bit_cnt + 1'b1;
                  if (r_bit_cnt == BW'(FRAME_BITS-1)) w_state_next = DONE;
               end
               if (w_sclk_fall) w_shift_next = {r_shift[FRAME_BITS-2:0], 1'b0};
            end
         end
         DONE: begin
            // Only a complete transfer of a real frame consumes it; aborts re-send the same head.
            if (w_cs_rise) begin
               w_pop        = r_loaded_valid;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_d       <= 1'b0;
         r_cs_d         <= 1'b1;
         r_state        <= IDLE;
         r_shift        <= '0;
         r_bit_cnt      <= '0;
         r_loaded_valid <= 1'b0;
         r_seq          <= '0;
         r_overflow     <= 1'b0;
         r_irq          <= 1'b0;
      end else begin
         r_sclk_d       <= w_sclk_s;
         r_cs_d         <= w_cs_s;
         r_state        <= w_state_next;
         r_shift        <= w_shift_next;
         r_bit_cnt      <= w_bit_cnt_next;
         r_loaded_valid <= w_loaded_valid_next;
         r_irq          <= (w_count != '0);
         if (w_push) r_seq <= r_seq + 1'b1;
         if (strike_in & w_fifo_full & ~w_pop)
            r_overflow <= 1'b1;
         else if (w_pop & w_head[FRAME_BITS-2])
            r_overflow <= 1'b0;
      end
   end

   assign miso     = (r_state == SHIFT) & r_shift[FRAME_BITS-1];
   assign irq      = r_irq;
   assign overflow = r_overflow;

endmodule
